key_debounce: RTL and testbench

Input conditioning stage for the reaction game, sitting directly upstream of the game controller. It synchronises and debounces the active-low push buttons, then produces clean per-key signals for the controller:

- stable level
- press pulse
- release pulse
- long-press pulse

It replaces the bare two-flop sync/edge logic in the top level, so contact bounce can no longer register as extra presses or score events.

---
 rtl/key_debounce.sv | 109 ++++++++++
 tb/tb_key_debounce.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// key_debounce: per-key synchroniser, debouncer and press/release/long-press pulse generator.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module key_debounce #(
   parameter int N_KEYS          = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int HOLD_CYCLES     = 50000000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              run_enable,
   input  logic [N_KEYS-1:0] key_n,
   output logic [N_KEYS-1:0] key_state,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_long
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW = $clog2(HOLD_CYCLES + 1);

   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESSED = 1'b1
   } key_fsm_t;

   for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      logic          sync1;
      logic          sync2;
      key_fsm_t      state;
      logic [DW-1:0] db_cnt;
      logic [HW-1:0] hold_cnt;
      logic          long_done;
      logic          press_q;
      logic          release_q;
      logic          long_q;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            state     <= IDLE;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            long_done <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
         end else if (!run_enable) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            state     <= IDLE;
            db_cnt    <= '0;
            hold_cnt  <= '0;
            long_done <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
         end else begin
            sync1     <= ~key_n[i];
            sync2     <= sync1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;

            // Hold counting first so that an accepted release below overrides it.
            if (state == PRESSED && hold_cnt != HOLD_MAX) begin
               hold_cnt <= hold_cnt + HW'(1);
               if (hold_cnt == HOLD_LAST && !long_done) begin
                  long_q    <= 1'b1;
                  long_done <= 1'b1;
               end
            end

            if (sync2 == (state == PRESSED)) begin
               db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
               db_cnt <= '0;
               if (state == IDLE) begin
                  state   <= PRESSED;
                  press_q <= 1'b1;
               end else begin
                  state     <= IDLE;
                  release_q <= 1'b1;
                  hold_cnt  <= '0;
                  long_done <= 1'b0;
                  long_q    <= 1'b0;
               end
            end else begin
               db_cnt <= db_cnt + DW'(1);
            end
         end
      end

      assign key_state[i]   = (state == PRESSED);
      assign key_press[i]   = press_q;
      assign key_release[i] = release_q;
      assign key_long[i]    = long_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scenario and randomized checks of key_debounce against a sample-window reference model.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_key_debounce;

   localparam int NK   = 2;
   localparam int DB   = 4;
   localparam int HOLD = 10;

   logic          clk        = 1'b0;
   logic          reset_n    = 1'b0;
   logic          run_enable = 1'b1;
   logic [NK-1:0] key_n      = 2'b11;
   logic [NK-1:0] key_state;
   logic [NK-1:0] key_press;
   logic [NK-1:0] key_release;
   logic [NK-1:0] key_long;
   logic [7:0]    dut_vec;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: a key toggles once the last DB synchronised samples all disagree with it.
   logic [DB:0]   hist [NK];
   int            held [NK];
   logic [NK-1:0] m_st, m_pr, m_rl, m_lg;

   key_debounce #(
      .N_KEYS          (NK),
      .DEBOUNCE_CYCLES (DB),
      .HOLD_CYCLES     (HOLD)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .run_enable  (run_enable),
      .key_n       (key_n),
      .key_state   (key_state),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long)
   );

   assign dut_vec = {key_state, key_press, key_release, key_long};

   always #5 clk = ~clk;

   function automatic void clear_model();
      for (int k = 0; k < NK; k++) begin
         hist[k] = '0;
         held[k] = 0;
      end
      m_st = '0;
      m_pr = '0;
      m_rl = '0;
      m_lg = '0;
   endfunction

   function automatic void model_edge();
      logic all_diff;
      m_pr = '0;
      m_rl = '0;
      m_lg = '0;
      if (!reset_n || !run_enable) begin
         clear_model();
         return;
      end
      for (int k = 0; k < NK; k++) begin
         all_diff = 1'b1;
         for (int j = 1; j <= DB; j++)
            if (hist[k][j] == m_st[k]) all_diff = 1'b0;
         hist[k] = {hist[k][DB-1:0], ~key_n[k]};
         if (all_diff) begin
            m_st[k] = ~m_st[k];
            held[k] = 0;
            if (m_st[k]) m_pr[k] = 1'b1;
            else         m_rl[k] = 1'b1;
         end else if (m_st[k] && held[k] < HOLD) begin
            held[k]++;
            if (held[k] == HOLD) m_lg[k] = 1'b1;
         end
      end
   endfunction

   function automatic logic [7:0] exp_vec();
      return {m_st, m_pr, m_rl, m_lg};
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n    = 1'b0;
      run_enable = 1'b1;
      key_n      = 2'b11;
      clear_model();
      repeat (3) begin
         step();
         vectors++;
         if (dut_vec !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_hold: got %b expected %b", dut_vec, 8'h00);
         end
      end
      reset_n = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         step();
         vectors++;
         if (dut_vec !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_release e=%0d: got %b expected %b", e, dut_vec, 8'h00);
         end
      end
   endtask

   task automatic test_clean_press();
      logic [3:0] want;
      for (int e = 1; e <= 45; e++) begin
         key_n = (e <= 30) ? 2'b10 : 2'b11;
         step();
         vectors++;
         if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL clean_press_model e=%0d: got %b expected %b", e, dut_vec, exp_vec());
         end
         want = {(e >= 6 && e < 36), (e == 6), (e == 16), (e == 36)};
         vectors++;
         if ({key_state[0], key_press[0], key_long[0], key_release[0]} !== want) begin
            miscompares++;
            $display("FAIL clean_press_timing e=%0d: got %b expected %b", e,
                     {key_state[0], key_press[0], key_long[0], key_release[0]}, want);
         end
      end
   endtask

   task automatic test_bounce();
      logic low;
      for (int e = 1; e <= 35; e++) begin
         low   = (e <= 3) || (e >= 5 && e <= 7) || (e >= 16 && e <= 21);
         key_n = {1'b1, ~low};
         step();
         vectors++;
         if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL bounce_model e=%0d: got %b expected %b", e, dut_vec, exp_vec());
         end
         if (e <= 21) begin
            vectors++;
            if (dut_vec !== ((e == 21) ? 8'b0101_0000 : 8'h00)) begin
               miscompares++;
               $display("FAIL bounce_reject e=%0d: got %b", e, dut_vec);
            end
         end
      end
   endtask

   task automatic test_simultaneous();
      for (int e = 1; e <= 25; e++) begin
         key_n = (e <= 10) ? 2'b00 : 2'b11;
         step();
         vectors++;
         if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL simultaneous_model e=%0d: got %b expected %b", e, dut_vec, exp_vec());
         end
         vectors++;
         if (key_press !== ((e == 6) ? 2'b11 : 2'b00) ||
             key_state !== ((e >= 6 && e < 16) ? 2'b11 : 2'b00)) begin
            miscompares++;
            $display("FAIL simultaneous_press e=%0d: got state=%b press=%b", e, key_state, key_press);
         end
         if (e == 16) begin
            vectors++;
            if (key_release !== 2'b11 || key_long !== 2'b00) begin
               miscompares++;
               $display("FAIL release_wins e=%0d: got release=%b long=%b expected 11/00", e, key_release, key_long);
            end
         end
      end
   endtask

   task automatic test_short_hold();
      int rel_count = 0;
      for (int e = 1; e <= 25; e++) begin
         key_n = (e <= 5) ? 2'b01 : 2'b11;
         step();
         if (key_release[1]) rel_count++;
         vectors++;
         if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL short_hold_model e=%0d: got %b expected %b", e, dut_vec, exp_vec());
         end
         vectors++;
         if (key_long[1] !== 1'b0 || key_state[1] !== (e >= 6 && e < 11) || key_release[1] !== (e == 11)) begin
            miscompares++;
            $display("FAIL short_hold e=%0d: got long=%b state=%b release=%b", e, key_long[1], key_state[1], key_release[1]);
         end
      end
      vectors++;
      if (rel_count != 1) begin
         miscompares++;
         $display("FAIL short_hold_release_count: got %0d expected 1", rel_count);
      end
   endtask

   task automatic test_run_enable();
      for (int e = 1; e <= 30; e++) begin
         key_n      = (e <= 20) ? 2'b10 : 2'b11;
         run_enable = !(e >= 9 && e <= 11);
         step();
         vectors++;
         if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL run_enable_model e=%0d: got %b expected %b", e, dut_vec, exp_vec());
         end
         if (e >= 9 && e <= 11) begin
            vectors++;
            if (dut_vec !== 8'h00) begin
               miscompares++;
               $display("FAIL run_enable_clear e=%0d: got %b expected 0", e, dut_vec);
            end
         end
         if (e >= 12 && e <= 20) begin
            vectors++;
            if (key_press[0] !== (e == 17)) begin
               miscompares++;
               $display("FAIL run_enable_repress e=%0d: got press=%b", e, key_press[0]);
            end
         end
      end
      run_enable = 1'b1;
   endtask

   task automatic test_async_reset();
      // Reset while the key is accepted as pressed.
      for (int e = 1; e <= 8; e++) begin
         key_n = 2'b10;
         step();
         vectors++;
         if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL async_pre_model e=%0d: got %b expected %b", e, dut_vec, exp_vec());
         end
      end
      #2 reset_n = 1'b0;
      #1;
      clear_model();
      vectors++;
      if (dut_vec !== 8'h00) begin
         miscompares++;
         $display("FAIL async_mid_press: got %b expected 0", dut_vec);
      end
      @(negedge clk);
      key_n = 2'b11;
      step();
      reset_n = 1'b1;
      // Reset with the debounce counter at 2.
      for (int e = 1; e <= 4; e++) begin
         key_n = 2'b10;
         step();
      end
      #2 reset_n = 1'b0;
      #1;
      clear_model();
      vectors++;
      if (dut_vec !== 8'h00) begin
         miscompares++;
         $display("FAIL async_mid_debounce: got %b expected 0", dut_vec);
      end
      @(negedge clk);
      key_n = 2'b11;
      step();
      reset_n = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         step();
         vectors++;
         if (dut_vec !== 8'h00 || exp_vec() !== 8'h00) begin
            miscompares++;
            $display("FAIL async_quiet e=%0d: got %b expected 0", e, dut_vec);
         end
      end
   endtask

   task automatic test_random();
      int            rem [NK];
      logic [NK-1:0] lvl;
      lvl = 2'b11;
      for (int k = 0; k < NK; k++) rem[k] = int'($urandom_range(5, 15));
      for (int c = 0; c < 800; c++) begin
         for (int k = 0; k < NK; k++) begin
            if (rem[k] == 0) begin
               lvl[k] = ~lvl[k];
               rem[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 20))
                                                    : int'($urandom_range(1, 6));
            end
            rem[k]--;
         end
         key_n      = lvl;
         run_enable = ($urandom_range(0, 99) >= 2);
         step();
         vectors++;
         if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL random c=%0d key_n=%b run=%b: got %b expected %b", c, key_n, run_enable, dut_vec, exp_vec());
         end
      end
      key_n      = 2'b11;
      run_enable = 1'b1;
   endtask

   initial begin
      clear_model();
      test_reset();
      test_clean_press();
      test_bounce();
      test_simultaneous();
      test_short_hold();
      test_run_enable();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
